// File: rtl/matmul_pcpi_core.sv
// PCPI coprocessor computing C = A*B + BIAS on an NxN output-stationary systolic array,
// with threshold mask and accumulator read-back. Optional build macro: MATMUL_RELU_EN.
module matmul_pcpi_core #(
    parameter int N  = 3,
    parameter int DW = 16,
    parameter int AW = 2*DW+4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam int NN = N*N;
    localparam int PW = 2*DW;
    localparam logic [7:0] K_LAST = 8'(3*N-3);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state;

    logic signed [DW-1:0] a_mat [NN];
    logic signed [DW-1:0] b_mat [NN];
    logic signed [DW-1:0] bias_mat [NN];
    logic signed [AW-1:0] acc [NN];
    logic signed [DW-1:0] a_reg [NN];
    logic signed [DW-1:0] b_reg [NN];
    logic signed [DW-1:0] a_in [NN];
    logic signed [DW-1:0] b_in [NN];
    logic signed [PW-1:0] prod [NN];
    logic signed [AW-1:0] acc_nxt [NN];
    logic signed [63:0]   acc64 [NN];
    logic signed [63:0]   nxt64 [NN];
    logic signed [63:0]   thr64;
    logic [7:0]  k;
    logic [31:0] thr;
    logic [31:0] mask;
    logic [31:0] mask_nxt;
    logic [31:0] rdc_val;
    logic [2:0]  funct3;
    logic        claim;
    logic        unused_bits;

    // Handshake: an insn is taken only while pcpi_valid is high in IDLE and no ready pulse is
    // being driven; pcpi_ready is a one-cycle pulse, pcpi_wr/pcpi_rd are meaningful only with it.
    assign funct3 = pcpi_insn[14:12];
    assign claim  = pcpi_valid && (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'd0) &&
                    (funct3[2:1] != 2'b11) && (state == IDLE) && !pcpi_ready;
    assign thr64  = {{32{thr[31]}}, thr};
    assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs2[31:DW]};

    always_comb begin
        mask_nxt = '0;
        rdc_val  = '0;
        for (int x = 0; x < NN; x++) begin
            a_in[x] = '0;
            b_in[x] = '0;
        end
        // Edge feeds are skewed by row/column so matching A/B elements meet in each PE.
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                if (k == 8'(i + m)) a_in[i*N] = a_mat[i*N + m];
                if (k == 8'(i + m)) b_in[i]   = b_mat[m*N + i];
            end
            for (int j = 1; j < N; j++) begin
                a_in[i*N + j] = a_reg[i*N + j - 1];
                b_in[j*N + i] = b_reg[(j-1)*N + i];
            end
        end
        for (int x = 0; x < NN; x++) begin
            prod[x]    = PW'(a_in[x]) * PW'(b_in[x]);
            acc_nxt[x] = ((k == 8'd0) ? AW'(bias_mat[x]) : acc[x]) + AW'(prod[x]);
            acc64[x]   = {{(64-AW){acc[x][AW-1]}}, acc[x]};
            nxt64[x]   = {{(64-AW){acc_nxt[x][AW-1]}}, acc_nxt[x]};
`ifdef MATMUL_RELU_EN
            mask_nxt[x] = (nxt64[x] >= thr64) && (nxt64[x] > 64'sd0);
            if (pcpi_rs1 == 32'(x)) rdc_val = (acc64[x] < 64'sd0) ? 32'd0 : acc64[x][31:0];
`else
            mask_nxt[x] = (nxt64[x] >= thr64);
            if (pcpi_rs1 == 32'(x)) rdc_val = acc64[x][31:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            k          <= '0;
            thr        <= '0;
            mask       <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
            for (int x = 0; x < NN; x++) begin
                a_mat[x]    <= '0;
                b_mat[x]    <= '0;
                bias_mat[x] <= '0;
                acc[x]      <= '0;
                a_reg[x]    <= '0;
                b_reg[x]    <= '0;
            end
        end else begin
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            case (state)
                IDLE: begin
                    if (claim) begin
                        case (funct3)
                            3'b000: begin
                                for (int x = 0; x < NN; x++) begin
                                    if (pcpi_rs1[7:0] == 8'(x))        a_mat[x]    <= pcpi_rs2[DW-1:0];
                                    if (pcpi_rs1[7:0] == 8'(NN + x))   b_mat[x]    <= pcpi_rs2[DW-1:0];
                                    if (pcpi_rs1[7:0] == 8'(2*NN + x)) bias_mat[x] <= pcpi_rs2[DW-1:0];
                                end
                                pcpi_ready <= 1'b1;
                            end
                            3'b001: begin
                                thr        <= pcpi_rs2;
                                pcpi_ready <= 1'b1;
                            end
                            3'b010: begin
                                state     <= COMPUTE;
                                k         <= '0;
                                pcpi_wait <= 1'b1;
                                for (int x = 0; x < NN; x++) begin
                                    a_reg[x] <= '0;
                                    b_reg[x] <= '0;
                                end
                            end
                            3'b011: begin
                                pcpi_ready <= 1'b1;
                                pcpi_wr    <= 1'b1;
                                pcpi_rd    <= rdc_val;
                            end
                            3'b100: begin
                                pcpi_ready <= 1'b1;
                                pcpi_wr    <= 1'b1;
                                pcpi_rd    <= mask;
                            end
                            3'b101: begin
                                for (int x = 0; x < NN; x++) begin
                                    a_mat[x]    <= '0;
                                    b_mat[x]    <= '0;
                                    bias_mat[x] <= '0;
                                end
                                mask       <= '0;
                                pcpi_ready <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                COMPUTE: begin
                    for (int x = 0; x < NN; x++) begin
                        acc[x]   <= acc_nxt[x];
                        a_reg[x] <= a_in[x];
                        b_reg[x] <= b_in[x];
                    end
                    // Mask comes from the final accumulator values so it is ready in DONE.
                    if (k == K_LAST) begin
                        state      <= DONE;
                        mask       <= mask_nxt;
                        pcpi_ready <= 1'b1;
                        pcpi_wr    <= 1'b1;
                        pcpi_rd    <= mask_nxt;
                        pcpi_wait  <= 1'b0;
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_pcpi_core.sv
// Bench for matmul_pcpi_core: directed steps plus randomized matrices against a reference model.
module tb_matmul_pcpi_core;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 2*DW+4;
  localparam int NN = N*N;
  localparam logic [6:0] OPC = 7'b0001011;
  localparam logic [2:0] F_WR = 3'd0, F_THR = 3'd1, F_START = 3'd2;
  localparam logic [2:0] F_RDC = 3'd3, F_RDM = 3'd4, F_CLR = 3'd5;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  longint ma[NN], mb[NN], mbias[NN], mc[NN];
  longint mthr;
  logic [31:0] mmask;

  matmul_pcpi_core #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic longint wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sext(input logic [31:0] v, input int w);
    longint t;
    t = longint'(v);
    return wrap(t, w);
  endfunction

  function automatic void model_reset();
    for (int x = 0; x < NN; x++) begin
      ma[x] = 0; mb[x] = 0; mbias[x] = 0; mc[x] = 0;
    end
    mthr  = 0;
    mmask = '0;
  endfunction

  function automatic void model_compute();
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = mbias[i*N + j];
        for (int m = 0; m < N; m++) s += ma[i*N + m] * mb[m*N + j];
        mc[i*N + j] = wrap(s, AW);
      end
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] r;
    r = '0;
    for (int x = 0; x < NN; x++) begin
`ifdef MATMUL_RELU_EN
      r[x] = (mc[x] >= mthr) && (mc[x] > 0);
`else
      r[x] = (mc[x] >= mthr);
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rdc(input int idx);
    longint v;
    if (idx < 0 || idx >= NN) return 32'd0;
    v = mc[idx];
`ifdef MATMUL_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
    return {f7, 5'd0, 5'd0, f3, 5'd0, opc};
  endfunction

  // driver tasks (all called and returning at a negedge)
  task automatic do_insn(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         output logic [31:0] rd, output logic wr, output logic wt,
                         output int lat, output logic wait_bad);
    bit seen;
    pcpi_insn  = enc(f3, 7'd0, OPC);
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
    pcpi_valid = 1'b1;
    lat = 0; wait_bad = 1'b0; rd = '0; wr = 1'b0; wt = 1'b0; seen = 1'b0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (pcpi_ready === 1'b1) begin
        seen = 1'b1; rd = pcpi_rd; wr = pcpi_wr; wt = pcpi_wait;
      end else if (pcpi_wait !== 1'b1) begin
        wait_bad = 1'b1;
      end
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'd0, pcpi_ready}, 32'd0);
  endtask

  task automatic op(input string tag, input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                    input logic [31:0] exp_rd, input logic exp_wr, input int exp_lat);
    logic [31:0] rd;
    logic wr, wt, wait_bad;
    int lat;
    do_insn(f3, rs1, rs2, rd, wr, wt, lat, wait_bad);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_wr"}, {31'd0, wr}, {31'd0, exp_wr});
    check({tag, "_wait_at_ready"}, {31'd0, wt}, 32'd0);
    if (exp_wr) check({tag, "_rd"}, rd, exp_rd);
    if (exp_lat > 1) check({tag, "_wait_busy"}, {31'd0, wait_bad}, 32'd0);
  endtask

  task automatic wr_el(input int idx, input logic [31:0] val);
    op("wr", F_WR, 32'(idx), val, 32'd0, 1'b0, 1);
    if (idx < NN) ma[idx] = sext(val, DW);
    else if (idx < 2*NN) mb[idx - NN] = sext(val, DW);
    else if (idx < 3*NN) mbias[idx - 2*NN] = sext(val, DW);
  endtask

  task automatic set_thr(input logic [31:0] v);
    op("thr", F_THR, 32'd0, v, 32'd0, 1'b0, 1);
    mthr = sext(v, 32);
  endtask

  task automatic clr();
    op("clr", F_CLR, 32'd0, 32'd0, 32'd0, 1'b0, 1);
    for (int x = 0; x < NN; x++) begin
      ma[x] = 0; mb[x] = 0; mbias[x] = 0;
    end
    mmask = '0;
  endtask

  task automatic run_start(input string tag, input logic [31:0] exp_mask);
    model_compute();
    mmask = model_mask();
    op(tag, F_START, 32'd0, 32'd0, exp_mask, 1'b1, 3*N - 1);
  endtask

  task automatic rdc_all(input string tag);
    logic [31:0] e;
    for (int x = 0; x < NN; x++) exp_q.push_back(model_rdc(x));
    for (int x = 0; x < NN; x++) begin
      e = exp_q.pop_front();
      op(tag, F_RDC, 32'(x), 32'd0, e, 1'b1, 1);
    end
  endtask

  task automatic offer_unclaimed(input string tag, input logic [31:0] insn, input int cycles);
    pcpi_insn = insn; pcpi_rs1 = 32'd0; pcpi_rs2 = 32'h0000_0055; pcpi_valid = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check(tag, {30'd0, pcpi_ready, pcpi_wait}, 32'd0);
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_drop(input string tag);
    int lat;
    logic [31:0] rd;
    logic wr;
    bit seen;
    model_compute();
    mmask = model_mask();
    pcpi_insn = enc(F_START, 7'd0, OPC); pcpi_rs1 = '0; pcpi_rs2 = '0; pcpi_valid = 1'b1;
    lat = 0; seen = 1'b0; rd = '0; wr = 1'b0;
    while (!seen && lat < 64) begin
      @(negedge clk);
      lat++;
      if (lat == 2) pcpi_valid = 1'b0;
      if (pcpi_ready === 1'b1) begin
        seen = 1'b1; rd = pcpi_rd; wr = pcpi_wr;
      end
    end
    pcpi_valid = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(3*N - 1));
    check({tag, "_wr"}, {31'd0, wr}, 32'd1);
    check({tag, "_rd"}, rd, mmask);
    @(negedge clk);
  endtask

  // stimulus
  initial begin
    int sel;
    logic [31:0] v;
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, pcpi_ready}, 32'd0);
    check("rst_wait", {31'd0, pcpi_wait}, 32'd0);
    check("rst_wr", {31'd0, pcpi_wr}, 32'd0);
    check("rst_rd", pcpi_rd, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: mask after reset
    op("t1_rdm", F_RDM, 32'd0, 32'd0, 32'd0, 1'b1, 1);

    // 2: identity times 1..9
    for (int x = 0; x < NN; x++) wr_el(x, (x % (N + 1) == 0) ? 32'd1 : 32'd0);
    for (int x = 0; x < NN; x++) wr_el(NN + x, 32'(x + 1));
    for (int x = 0; x < NN; x++) wr_el(2*NN + x, 32'd0);
    set_thr(32'd5);
    run_start("t2_start", 32'h0000_01F0);
    op("t2_rdc7", F_RDC, 32'd7, 32'd0, 32'd8, 1'b1, 1);
    op("t2_rdm", F_RDM, 32'd0, 32'd0, 32'h0000_01F0, 1'b1, 1);

    // 3: all -2 with negative bias on element 0
    for (int x = 0; x < 2*NN; x++) wr_el(x, 32'hFFFF_FFFE);
    wr_el(2*NN, 32'hFFFF_FFEC);
    for (int x = 1; x < NN; x++) wr_el(2*NN + x, 32'd0);
    set_thr(32'd0);
    run_start("t3_start", 32'h0000_01FE);
    op("t3_rdc0", F_RDC, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1, 1);
    op("t3_rdc1", F_RDC, 32'd1, 32'd0, 32'd12, 1'b1, 1);

    // 4: out-of-range accesses and ignored encodings leave state alone
    wr_el(200, 32'h0000_7777);
    op("t4_rdc9", F_RDC, 32'd9, 32'd0, 32'd0, 1'b1, 1);
    offer_unclaimed("t4_funct7", {7'd1, 5'd0, 5'd0, F_WR, 5'd0, OPC}, 4);
    start_drop("t4_drop");
    rdc_all("t4_rdc");

    // randomized matrices
    for (int it = 0; it < 5; it++) begin
      for (int x = 0; x < 3*NN; x++) begin
        if (it % 2 == 0) v = $urandom();
        else v = 32'($urandom_range(0, 16)) - 32'd8;
        wr_el(x, v);
      end
      model_compute();
      sel = $urandom_range(0, 2);
      if (sel == 0) v = $urandom();
      else if (sel == 1) v = mc[$urandom_range(0, NN - 1)][31:0];
      else v = 32'd0;
      set_thr(v);
      run_start("rnd_start", model_mask());
      rdc_all("rnd_rdc");
      op("rnd_rdm", F_RDM, 32'd0, 32'd0, mmask, 1'b1, 1);
    end

    // 5: reset during COMPUTE cycle 3
    pcpi_insn = enc(F_START, 7'd0, OPC); pcpi_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_busy_before_reset", {31'd0, pcpi_wait}, 32'd1);
    resetn = 1'b0; pcpi_valid = 1'b0;
    #1;
    check("t5_wait_cleared", {31'd0, pcpi_wait}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_no_ready", {31'd0, pcpi_ready}, 32'd0);
      if (c == 2) resetn = 1'b1;
    end
    model_reset();
    op("t5_rdm", F_RDM, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    op("t5_rdc0", F_RDC, 32'd0, 32'd0, 32'd0, 1'b1, 1);

    // 6: unclaimed encodings, then clear and recompute
    for (int x = 0; x < 3*NN; x++) wr_el(x, (x < 2*NN) ? 32'(x + 3) : 32'hFFFF_FFFF - 32'(x));
    offer_unclaimed("t6_f3_110", enc(3'b110, 7'd0, OPC), 20);
    offer_unclaimed("t6_f3_111", enc(3'b111, 7'd0, OPC), 4);
    offer_unclaimed("t6_opcode", enc(F_START, 7'd0, 7'b0110011), 4);
    set_thr(32'd1);
    clr();
    op("t6_rdm_after_clr", F_RDM, 32'd0, 32'd0, 32'd0, 1'b1, 1);
    run_start("t6_start_thr1", 32'd0);
    set_thr(32'd0);
    run_start("t6_start_thr0", 32'h0000_01FF);
    rdc_all("t6_rdc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
